// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational full adder built from two half adders, used as the
// one-bit datapath of the serial adder.
module halfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  halfAdder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  halfAdder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands shift through one full-adder cell LSB first,
// one bit per cycle, with the result published on the RUN->DONE edge.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa, sb, res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_bit;

  fa_cell u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            res   <= '0;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= c_bit;
          res   <= {s_bit, res[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          // The last bit's sum is still combinational here, so it is merged in directly.
          if (cnt == LAST) begin
            sum   <= {s_bit, res[WIDTH-1:1]};
            cout  <= c_bit;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 (scenarios) and WIDTH=4 (exhaustive back-to-back).
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic       rst8, start8, cin8, ready8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       rst4, start4, cin4, ready4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     input logic [7:0] esum, input logic ecout);
    int lat;
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    vectors++;
    if (busy8 !== 1'b1 || ready8 !== 1'b0) begin
      miscompares++;
      $display("FAIL op8_accept a=%h b=%h: busy=%b ready=%b, required busy=1 ready=0", ta, tb, busy8, ready8);
    end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done8 === 1'b1) begin
        lat = i;
        break;
      end
    end
    vectors++;
    if (lat != 8) begin
      miscompares++;
      $display("FAIL op8_latency a=%h b=%h: done after %0d cycles (0=timeout), required 8", ta, tb, lat);
    end
    vectors++;
    if (sum8 !== esum || cout8 !== ecout) begin
      miscompares++;
      $display("FAIL op8_result a=%h b=%h cin=%b: cout,sum=%b,%h required %b,%h", ta, tb, tc, cout8, sum8, ecout, esum);
    end
    tick();
    vectors++;
    if (ready8 !== 1'b1 || done8 !== 1'b0) begin
      miscompares++;
      $display("FAIL op8_return a=%h b=%h: ready=%b done=%b, required ready=1 done=0", ta, tb, ready8, done8);
    end
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst4 = 1'b1;
    start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    tick();
    tick();
    vectors++;
    if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset8: ready=%b busy=%b done=%b sum=%h cout=%b, required 1 0 0 00 0", ready8, busy8, done8, sum8, cout8);
    end
    vectors++;
    if (ready4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 4'h0 || cout4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset4: ready=%b busy=%b done=%b sum=%h cout=%b, required 1 0 0 0 0", ready4, busy4, done4, sum4, cout4);
    end
    rst8 = 1'b0; rst4 = 1'b0;
  endtask

  task automatic test_zero();
    op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_overflow();
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    op8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
  endtask

  task automatic test_start_ignored();
    int dones;
    dones = 0;
    a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    a8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done8 === 1'b1) break;
      vectors++;
      if (ready8 !== 1'b0) begin
        miscompares++;
        $display("FAIL ignore_ready_run: ready=%b, required 0", ready8);
      end
      tick();
    end
    if (done8 === 1'b1) dones++;
    vectors++;
    if (sum8 !== 8'h4B || cout8 !== 1'b0 || ready8 !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_result: sum=%h cout=%b ready=%b, required 4b 0 0", sum8, cout8, ready8);
    end
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    if (done8 === 1'b1) dones++;
    vectors++;
    if (ready8 !== 1'b1 || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_done_start: ready=%b busy=%b, required 1 0", ready8, busy8);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 === 1'b1) dones++;
    end
    vectors++;
    if (dones != 1 || sum8 !== 8'h4B) begin
      miscompares++;
      $display("FAIL ignore_single_done: dones=%0d sum=%h, required 1 4b", dones, sum8);
    end
  endtask

  task automatic test_reset_mid_run();
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    vectors++;
    if (done8 !== 1'b0 || ready8 !== 1'b1 || busy8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: done=%b ready=%b busy=%b sum=%h cout=%b, required 0 1 0 00 0", done8, ready8, busy8, sum8, cout8);
    end
    op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
  endtask

  task automatic test_back_to_back_w4();
    int dones;
    logic [3:0] prev_sum;
    logic       prev_cout;
    logic [4:0] expv;
    dones = 0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
          prev_sum = sum4; prev_cout = cout4;
          expv = 5'(ia + ib + ic);
          tick();
          start4 = 1'b0;
          a4 = ~a4; b4 = ~b4; cin4 = ~cin4;
          for (int k = 1; k <= 4; k++) begin
            tick();
            if (done4 === 1'b1) dones++;
            if (k < 4) begin
              vectors++;
              if (done4 !== 1'b0 || sum4 !== prev_sum || cout4 !== prev_cout) begin
                miscompares++;
                $display("FAIL w4_hold a=%0d b=%0d c=%0d k=%0d: done=%b cout,sum=%b,%h required 0 %b,%h",
                         ia, ib, ic, k, done4, cout4, sum4, prev_cout, prev_sum);
              end
            end
          end
          vectors++;
          if (done4 !== 1'b1 || {cout4, sum4} !== expv) begin
            miscompares++;
            $display("FAIL w4_result a=%0d b=%0d c=%0d: done=%b cout,sum=%b%h required done=1 %h",
                     ia, ib, ic, done4, cout4, sum4, expv);
          end
          tick();
          if (done4 === 1'b1) dones++;
        end
      end
    end
    vectors++;
    if (dones != 512) begin
      miscompares++;
      $display("FAIL w4_done_count: %0d pulses, required 512", dones);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_overflow();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back_w4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
